// File: rtl/fpmult_pkg.sv
// fpmult_pkg: shared constants, FSM state type and helpers for the FPMult execute stage.
`default_nettype none

package fpmult_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int SPLIT  = 17;
    localparam int CHUNK  = 4;
    localparam int BIAS   = 127;
    localparam int NCHUNK = (SPLIT + CHUNK - 1) / CHUNK;
    localparam int PROD_W = 2 * (MAN_W + 1);
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Exception flag bit positions within {any, ANaN, BNaN, AInf, BInf}
    localparam int EXC_ANY  = 4;
    localparam int EXC_ANAN = 3;
    localparam int EXC_BNAN = 2;
    localparam int EXC_AINF = 1;
    localparam int EXC_BINF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two extra bits keep exponent overflow and underflow visible as two's complement.
    function automatic logic [EXP_W+1:0] calc_ep(input logic [EXP_W-1:0] ea,
                                                 input logic [EXP_W-1:0] eb,
                                                 input logic             norm);
        return {2'b00, ea} + {2'b00, eb} - (EXP_W+2)'(BIAS)
               + {{(EXP_W+1){1'b0}}, norm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpmult_exec_mac.sv
// fpmult_exec_mac: one serial multiply-accumulate step, acc + ({1,Ma} * chunk << idx*CHUNK).
`default_nettype none

module fpmult_exec_mac
    import fpmult_pkg::*;
(
    input  logic [PROD_W-1:0] acc,
    input  logic [MAN_W:0]    mant,
    input  logic [CHUNK-1:0]  chunk,
    input  logic [CNT_W-1:0]  idx,
    output logic [PROD_W-1:0] sum
);

    logic [MAN_W+CHUNK:0] term;
    logic [PROD_W-1:0]    term_sh;

    assign term    = {{CHUNK{1'b0}}, mant} * {{(MAN_W+1){1'b0}}, chunk};
    assign term_sh = PROD_W'(term) << (int'(idx) * CHUNK);
    assign sum     = acc + term_sh;

endmodule

`default_nettype wire

// File: rtl/fpmult_exec_stage.sv
// fpmult_exec_stage: FPMult execute stage - serial low-mantissa MAC, normalise, sign/exponent.
// Optional macro FPMULT_EXEC_GRS_EN enables the guard/sticky outputs.  Rev 1.0
`default_nettype none

module fpmult_exec_stage
    import fpmult_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sa,
    input  logic                in_sb,
    input  logic [EXP_W-1:0]    in_ea,
    input  logic [EXP_W-1:0]    in_eb,
    input  logic [MAN_W-1:0]    in_ma,
    input  logic [SPLIT-1:0]    in_mb_lo,
    input  logic [PROD_W-1:0]   in_mp,
    input  logic [4:0]          in_exc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sp,
    output logic [EXP_W+1:0]    out_ep,
    output logic [MAN_W:0]      out_mn,
    output logic                out_norm,
    output logic [1:0]          out_grs,
    output logic [4:0]          out_exc
);

    localparam int               MB_W   = NCHUNK * CHUNK;
    localparam int               G_IDX  = PROD_W - MAN_W - 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   acc_nxt;
    logic                sa;
    logic                sb;
    logic [EXP_W-1:0]    ea;
    logic [EXP_W-1:0]    eb;
    logic [MAN_W-1:0]    ma;
    logic [MB_W-1:0]     mb_pad;
    logic [4:0]          exc;

    logic                accept;
    logic                last;
    logic [CHUNK-1:0]    chunk;
    logic                norm_w;
    logic [MAN_W:0]      mn_w;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (state == MUL) && (cnt == CNT_LAST);
    assign chunk     = mb_pad[int'(cnt) * CHUNK +: CHUNK];

    fpmult_exec_mac u_mac (
        .acc   (acc),
        .mant  ({1'b1, ma}),
        .chunk (chunk),
        .idx   (cnt),
        .sum   (acc_nxt)
    );

    // Normalisation looks at the accumulator including the final chunk.
    assign norm_w = acc_nxt[PROD_W-1];
    assign mn_w   = norm_w ? acc_nxt[PROD_W-1 -: MAN_W+1] : acc_nxt[PROD_W-2 -: MAN_W+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_exc[EXC_ANY] ? DONE : MUL;
                end
            end
            MUL: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            acc      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            ea       <= '0;
            eb       <= '0;
            ma       <= '0;
            mb_pad   <= '0;
            exc      <= '0;
            out_sp   <= 1'b0;
            out_ep   <= '0;
            out_mn   <= '0;
            out_norm <= 1'b0;
            out_exc  <= '0;
        end else begin
            if (accept) begin
                sa     <= in_sa;
                sb     <= in_sb;
                ea     <= in_ea;
                eb     <= in_eb;
                ma     <= in_ma;
                mb_pad <= MB_W'(in_mb_lo);
                exc    <= in_exc;
                acc    <= in_mp << SPLIT;
                cnt    <= '0;
                // Exceptional operands skip the MAC; the result is formed right away.
                if (in_exc[EXC_ANY]) begin
                    out_sp   <= in_sa ^ in_sb;
                    out_ep   <= calc_ep(in_ea, in_eb, 1'b0);
                    out_mn   <= '0;
                    out_norm <= 1'b0;
                    out_exc  <= in_exc;
                end
            end else if (state == MUL) begin
                acc <= acc_nxt;
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    out_sp   <= sa ^ sb;
                    out_ep   <= calc_ep(ea, eb, norm_w);
                    out_mn   <= mn_w;
                    out_norm <= norm_w;
                    out_exc  <= exc;
                end
            end
        end
    end

`ifdef FPMULT_EXEC_GRS_EN
    logic [1:0] grs_q;
    logic       guard_w;
    logic       sticky_w;

    assign guard_w  = norm_w ? acc_nxt[G_IDX] : acc_nxt[G_IDX-1];
    assign sticky_w = norm_w ? (|acc_nxt[G_IDX-1:0]) : (|acc_nxt[G_IDX-2:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grs_q <= 2'b00;
        end else if (accept && in_exc[EXC_ANY]) begin
            grs_q <= 2'b00;
        end else if (last) begin
            grs_q <= {guard_w, sticky_w};
        end
    end

    assign out_grs = grs_q;
`else
    assign out_grs = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpmult_exec_stage.sv
// tb_fpmult_exec_stage: directed and randomized checks of fpmult_exec_stage against a real-product model.
`default_nettype none

module tb_fpmult_exec_stage;

    localparam int NCH = 5;

    typedef struct packed {
        logic        sp;
        logic [9:0]  ep;
        logic [23:0] mn;
        logic        norm;
        logic [1:0]  grs;
        logic [4:0]  exc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sa = 1'b0;
    logic        in_sb = 1'b0;
    logic [7:0]  in_ea = '0;
    logic [7:0]  in_eb = '0;
    logic [22:0] in_ma = '0;
    logic [16:0] in_mb_lo = '0;
    logic [47:0] in_mp = '0;
    logic [4:0]  in_exc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sp;
    logic [9:0]  out_ep;
    logic [23:0] out_mn;
    logic        out_norm;
    logic [1:0]  out_grs;
    logic [4:0]  out_exc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpmult_exec_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sa     (in_sa),
        .in_sb     (in_sb),
        .in_ea     (in_ea),
        .in_eb     (in_eb),
        .in_ma     (in_ma),
        .in_mb_lo  (in_mb_lo),
        .in_mp     (in_mp),
        .in_exc    (in_exc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sp    (out_sp),
        .out_ep    (out_ep),
        .out_mn    (out_mn),
        .out_norm  (out_norm),
        .out_grs   (out_grs),
        .out_exc   (out_exc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact 24x24 mantissa product, normalised into [1,2) with a 1-bit exponent bump.
    function automatic res_t model(input bit sa, input bit sb, input bit [7:0] ea, input bit [7:0] eb,
                                   input bit [22:0] ma, input bit [22:0] mb, input bit [4:0] exc);
        res_t r;
        longint unsigned fa, fb, p;
        int e;
        bit g, s;
        fa = {1'b1, ma};
        fb = {1'b1, mb};
        p  = fa * fb;
        r.sp  = sa ^ sb;
        r.exc = exc;
        if (exc[4]) begin
            r.norm = 1'b0;
            r.mn   = '0;
            r.grs  = 2'b00;
        end else begin
            r.norm = (p >= 64'h8000_0000_0000);
            if (r.norm) begin
                r.mn = 24'(p >> 24);
                g    = ((p >> 23) % 2) == 1;
                s    = (p % 64'h80_0000) != 0;
            end else begin
                r.mn = 24'(p >> 23);
                g    = ((p >> 22) % 2) == 1;
                s    = (p % 64'h40_0000) != 0;
            end
`ifdef FPMULT_EXEC_GRS_EN
            r.grs = {g, s};
`else
            r.grs = 2'b00;
`endif
        end
        e    = int'(ea) + int'(eb) - 127 + int'(r.norm);
        r.ep = e[9:0];
        return r;
    endfunction

    task automatic run_op(input string tag, input bit sa, input bit sb, input bit [7:0] ea,
                          input bit [7:0] eb, input bit [22:0] ma, input bit [22:0] mb,
                          input bit [4:0] exc, input int hold);
        res_t r;
        int lat;
        logic [47:0] a48, b48;
        r   = model(sa, sb, ea, eb, ma, mb, exc);
        a48 = {1'b1, ma};
        b48 = {1'b1, mb[22:17]};
        @(negedge clk);
        check({tag, " in_ready idle"}, in_ready, 1'b1);
        in_sa    = sa;
        in_sb    = sb;
        in_ea    = ea;
        in_eb    = eb;
        in_ma    = ma;
        in_mb_lo = mb[16:0];
        in_mp    = a48 * b48;
        in_exc   = exc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Busy-time traffic that must be ignored
        in_ma    = 23'($urandom);
        in_mb_lo = 17'($urandom);
        in_mp    = {16'($urandom), 32'($urandom)};
        in_ea    = 8'($urandom);
        in_exc   = 5'b10000;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        in_exc   = '0;
        check({tag, " latency"}, 64'(lat), exc[4] ? 64'd0 : 64'(NCH));
        check({tag, " valid"}, out_valid, 1'b1);
        check({tag, " sp"}, out_sp, r.sp);
        check({tag, " ep"}, out_ep, r.ep);
        check({tag, " mn"}, out_mn, r.mn);
        check({tag, " norm"}, out_norm, r.norm);
        check({tag, " grs"}, out_grs, r.grs);
        check({tag, " exc"}, out_exc, r.exc);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, out_valid, 1'b1);
            check({tag, " hold mn"}, out_mn, r.mn);
            check({tag, " hold ep"}, out_ep, r.ep);
            check({tag, " hold in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " valid drop"}, out_valid, 1'b0);
        check({tag, " in_ready back"}, in_ready, 1'b1);
    endtask

    initial begin
        int seen;
        bit [4:0] rexc;

        #12;
        check("reset valid", out_valid, 1'b0);
        check("reset mn", out_mn, 24'h0);
        check("reset ep", out_ep, 10'h0);
        check("reset exc", out_exc, 5'h0);
        check("reset grs", out_grs, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready after reset", in_ready, 1'b1);

        // 1.0 x 1.0, then 1.5 x 1.5 with a 10-cycle back-pressure hold
        run_op("one_x_one", 1'b0, 1'b0, 8'd127, 8'd127, 23'h0, 23'h0, 5'b0, 0);
        run_op("onehalf_sq", 1'b0, 1'b0, 8'd127, 8'd127, 23'h400000, 23'h400000, 5'b0, 10);
        run_op("lsb_sticky", 1'b1, 1'b0, 8'd127, 8'd127, 23'h1, 23'h1, 5'b0, 1);
        run_op("exc_path", 1'b1, 1'b1, 8'hFF, 8'h80, 23'h123, 23'h456, 5'b10010, 2);
        run_op("max_mant", 1'b0, 1'b1, 8'd254, 8'd254, 23'h7FFFFF, 23'h7FFFFF, 5'b0, 0);
        run_op("underflow", 1'b0, 1'b0, 8'd1, 8'd2, 23'h0ABCDE, 23'h012345, 5'b0, 0);

        // Reset in the third MUL cycle discards the operation
        @(negedge clk);
        in_sa    = 1'b1;
        in_ea    = 8'd130;
        in_eb    = 8'd131;
        in_ma    = 23'h2AAAAA;
        in_mb_lo = 17'h15555;
        in_mp    = 48'h0000_1234_5678;
        in_exc   = 5'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("midreset valid", out_valid, 1'b0);
        check("midreset mn", out_mn, 24'h0);
        check("midreset ep", out_ep, 10'h0);
        check("midreset sp", out_sp, 1'b0);
        check("midreset norm", out_norm, 1'b0);
        check("midreset exc", out_exc, 5'h0);
        check("midreset grs", out_grs, 2'b00);
        check("midreset in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("no valid after reset", 64'(seen), 64'd0);
        run_op("after_reset", 1'b0, 1'b1, 8'd100, 8'd150, 23'h3C0F0F, 23'h1E1E1E, 5'b0, 1);

        // Randomized operands, occasional exceptions and back-pressure
        for (int n = 0; n < 25; n++) begin
            rexc = ($urandom_range(0, 4) == 0) ? {1'b1, 4'($urandom)} : 5'b0;
            run_op("random", 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                   23'($urandom), 23'($urandom), rexc, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
